// File: rtl/pcie_cfg_tracker.sv
// -----------------------------------------------------------------------------
// pcie_cfg_tracker
//
// Purpose:
//   Tracks the PCIe hard-IP link state. It produces a debounced link-up, a
//   sticky "L0 seen" flag and a saturating count of link drops. It also snoops
//   the tl_cfg sideband bus to hold a per-PF copy of the MPS, MRRS, ext-tag,
//   MSI-X enable and MSI-X function-mask settings.
//
// Ports:
//   avl_clk              sole clock, rising edge
//   avl_rst_n            synchronous active-low reset
//   i_ltssmstate[5:0]    LTSSM state from the hard IP
//   i_hip_linkup         hard-IP data-link-up
//   i_tl_cfg_func[1:0]   function index of the current tl_cfg word
//   i_tl_cfg_add[3:0]    tl_cfg address
//   i_tl_cfg_ctl[31:0]   tl_cfg data
//   o_pcie_linkup        debounced link-up (high while the FSM is UP)
//   o_cfg_bd_done        sticky, set once L0 has been seen
//   o_max_payload_size   per-PF MPS, PF n at [3n+2:3n]
//   o_max_read_req_size  per-PF MRRS, same packing
//   o_ext_tag_en         per-PF extended tag enable
//   o_msix_en            per-PF MSI-X enable
//   o_msix_pf_mask       per-PF MSI-X function mask
//   o_cfg_update         one-cycle pulse per PF whose registers were written
//   o_link_down_cnt      saturating count of UP->DOWN transitions
//
// Build option:
//   PCIE_CFG_LINKDOWN_CLR_EN  when defined, all per-PF config registers clear
//                             on the UP->DOWN transition. Otherwise they keep
//                             their values.
// -----------------------------------------------------------------------------
module pcie_cfg_tracker #(
    parameter int unsigned NUM_PF       = 4,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter logic [5:0]  LTSSM_L0     = 6'h11
) (
    input  logic                  avl_clk,
    input  logic                  avl_rst_n,
    input  logic [5:0]            i_ltssmstate,
    input  logic                  i_hip_linkup,
    input  logic [1:0]            i_tl_cfg_func,
    input  logic [3:0]            i_tl_cfg_add,
    input  logic [31:0]           i_tl_cfg_ctl,
    output logic                  o_pcie_linkup,
    output logic                  o_cfg_bd_done,
    output logic [3*NUM_PF-1:0]   o_max_payload_size,
    output logic [3*NUM_PF-1:0]   o_max_read_req_size,
    output logic [NUM_PF-1:0]     o_ext_tag_en,
    output logic [NUM_PF-1:0]     o_msix_en,
    output logic [NUM_PF-1:0]     o_msix_pf_mask,
    output logic [NUM_PF-1:0]     o_cfg_update,
    output logic [15:0]           o_link_down_cnt
);

    typedef enum logic [1:0] {
        ST_DOWN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_UP       = 2'd2
    } state_e;

    localparam logic [7:0] DBC_TARGET = 8'(DEBOUNCE_CYC);
    localparam logic [2:0] NUM_PF_W   = 3'(NUM_PF);

    state_e        state_q;
    logic [5:0]    ltssm_q;
    logic [7:0]    dbc_q;
    logic          linkup_q;
    logic          bd_done_q;
    logic [15:0]   down_cnt_q;

    logic [3*NUM_PF-1:0] mps_q,  mps_d;
    logic [3*NUM_PF-1:0] mrrs_q, mrrs_d;
    logic [NUM_PF-1:0]   ext_q,  ext_d;
    logic [NUM_PF-1:0]   msix_q, msix_d;
    logic [NUM_PF-1:0]   mask_q, mask_d;
    logic [NUM_PF-1:0]   upd_q,  upd_d;

    logic l0_q;
    logic qual;
    logic up_to_down;
    logic cap_ok;

    // Only ctl[6:0] carries fields this block captures.
    logic unused_ctl;
    assign unused_ctl = ^i_tl_cfg_ctl[31:7];

    assign l0_q       = (ltssm_q == LTSSM_L0);
    assign qual       = l0_q & i_hip_linkup;
    assign up_to_down = (state_q == ST_UP) & ~qual;
    // Words for function indices beyond NUM_PF belong to other logic.
    assign cap_ok     = l0_q & ({1'b0, i_tl_cfg_func} < NUM_PF_W);

    // Link state FSM with registered outputs.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would leak new values into later
    // statements of the same edge.
    always_ff @(posedge avl_clk) begin
        if (!avl_rst_n) begin
            state_q    <= ST_DOWN;
            ltssm_q    <= '0;
            dbc_q      <= '0;
            linkup_q   <= 1'b0;
            bd_done_q  <= 1'b0;
            down_cnt_q <= '0;
        end else begin
            ltssm_q <= i_ltssmstate;
            if (l0_q) begin
                bd_done_q <= 1'b1;
            end
            case (state_q)
                ST_DOWN: begin
                    if (qual) begin
                        state_q <= ST_DEBOUNCE;
                        dbc_q   <= 8'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!qual) begin
                        state_q <= ST_DOWN;
                        dbc_q   <= '0;
                    end else if (dbc_q == DBC_TARGET) begin
                        state_q  <= ST_UP;
                        linkup_q <= 1'b1;
                    end else begin
                        dbc_q <= dbc_q + 8'd1;
                    end
                end
                ST_UP: begin
                    if (up_to_down) begin
                        state_q  <= ST_DOWN;
                        linkup_q <= 1'b0;
                        dbc_q    <= '0;
                        if (down_cnt_q != 16'hFFFF) begin
                            down_cnt_q <= down_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_DOWN;
                    linkup_q <= 1'b0;
                    dbc_q    <= '0;
                end
            endcase
        end
    end

    // Per-PF config capture.
    always_comb begin
        // NOTE: each _d starts from a full default so no path leaves it
        // unassigned, which would otherwise infer a latch.
        mps_d  = mps_q;
        mrrs_d = mrrs_q;
        ext_d  = ext_q;
        msix_d = msix_q;
        mask_d = mask_q;
        upd_d  = '0;
        if (cap_ok) begin
            for (int n = 0; n < int'(NUM_PF); n++) begin
                if (i_tl_cfg_func == 2'(n)) begin
                    case (i_tl_cfg_add)
                        4'h0: begin
                            mps_d[3*n +: 3]  = i_tl_cfg_ctl[2:0];
                            mrrs_d[3*n +: 3] = i_tl_cfg_ctl[5:3];
                            ext_d[n]         = i_tl_cfg_ctl[6];
                            upd_d[n]         = 1'b1;
                        end
                        4'h6: begin
                            msix_d[n] = i_tl_cfg_ctl[5];
                            mask_d[n] = i_tl_cfg_ctl[6];
                            upd_d[n]  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
`ifdef PCIE_CFG_LINKDOWN_CLR_EN
        // Link loss wins over a capture in the same cycle and raises no update.
        if (up_to_down) begin
            mps_d  = '0;
            mrrs_d = '0;
            ext_d  = '0;
            msix_d = '0;
            mask_d = '0;
            upd_d  = '0;
        end
`endif
    end

    always_ff @(posedge avl_clk) begin
        if (!avl_rst_n) begin
            mps_q  <= '0;
            mrrs_q <= '0;
            ext_q  <= '0;
            msix_q <= '0;
            mask_q <= '0;
            upd_q  <= '0;
        end else begin
            mps_q  <= mps_d;
            mrrs_q <= mrrs_d;
            ext_q  <= ext_d;
            msix_q <= msix_d;
            mask_q <= mask_d;
            upd_q  <= upd_d;
        end
    end

    assign o_pcie_linkup       = linkup_q;
    assign o_cfg_bd_done       = bd_done_q;
    assign o_link_down_cnt     = down_cnt_q;
    assign o_max_payload_size  = mps_q;
    assign o_max_read_req_size = mrrs_q;
    assign o_ext_tag_en        = ext_q;
    assign o_msix_en           = msix_q;
    assign o_msix_pf_mask      = mask_q;
    assign o_cfg_update        = upd_q;

endmodule

// File: tb/tb_pcie_cfg_tracker.sv
// -----------------------------------------------------------------------------
// tb_pcie_cfg_tracker
//
// Self-checking bench for pcie_cfg_tracker with NUM_PF=3 and DEBOUNCE_CYC=16.
// NUM_PF=3 makes func=3 an out-of-range function.
//
// The reference model tracks link state as the number of consecutive qualified
// edges. The link is up once that run exceeds DEBOUNCE_CYC. The model also keeps
// plain per-PF arrays for the config fields. One compare process checks every
// output against the model on each falling edge. Directed sequences add literal
// expectations at the key points.
// -----------------------------------------------------------------------------
module tb_pcie_cfg_tracker;

    localparam int         NPF = 3;
    localparam int         DBC = 16;
    localparam logic [5:0] L0  = 6'h11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n      = 1'b0;
    logic [5:0]        ltssm      = '0;
    logic              hip_linkup = 1'b0;
    logic [1:0]        cfg_func   = '0;
    logic [3:0]        cfg_add    = 4'hF;
    logic [31:0]       cfg_ctl    = '0;

    logic              pcie_linkup;
    logic              bd_done;
    logic [3*NPF-1:0]  mps;
    logic [3*NPF-1:0]  mrrs;
    logic [NPF-1:0]    ext_tag;
    logic [NPF-1:0]    msix_en;
    logic [NPF-1:0]    msix_mask;
    logic [NPF-1:0]    cfg_update;
    logic [15:0]       down_cnt;

    pcie_cfg_tracker #(
        .NUM_PF       (NPF),
        .DEBOUNCE_CYC (DBC),
        .LTSSM_L0     (L0)
    ) dut (
        .avl_clk             (clk),
        .avl_rst_n           (rst_n),
        .i_ltssmstate        (ltssm),
        .i_hip_linkup        (hip_linkup),
        .i_tl_cfg_func       (cfg_func),
        .i_tl_cfg_add        (cfg_add),
        .i_tl_cfg_ctl        (cfg_ctl),
        .o_pcie_linkup       (pcie_linkup),
        .o_cfg_bd_done       (bd_done),
        .o_max_payload_size  (mps),
        .o_max_read_req_size (mrrs),
        .o_ext_tag_en        (ext_tag),
        .o_msix_en           (msix_en),
        .o_msix_pf_mask      (msix_mask),
        .o_cfg_update        (cfg_update),
        .o_link_down_cnt     (down_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit         m_valid = 0;
    logic [5:0] m_ltssm;
    int         m_run;
    bit         m_linkup;
    bit         m_bd;
    int         m_dcnt;
    logic [2:0] m_mps  [NPF];
    logic [2:0] m_mrrs [NPF];
    bit         m_ext  [NPF];
    bit         m_msix [NPF];
    bit         m_mask [NPF];
    bit         m_upd  [NPF];

    task automatic model_clear_cfg();
        for (int n = 0; n < NPF; n++) begin
            m_mps[n] = '0; m_mrrs[n] = '0;
            m_ext[n] = 0;  m_msix[n] = 0; m_mask[n] = 0;
        end
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit l0, qual, drop;
        if (!rst_n) begin
            m_valid = 1; m_ltssm = '0; m_run = 0; m_linkup = 0; m_bd = 0; m_dcnt = 0;
            model_clear_cfg();
            for (int n = 0; n < NPF; n++) m_upd[n] = 0;
            return;
        end
        l0   = (m_ltssm == L0);
        qual = l0 && hip_linkup;
        drop = m_linkup && !qual;
        if (drop && m_dcnt < 65535) m_dcnt++;
        m_run    = qual ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        m_linkup = (m_run > DBC);
        if (l0) m_bd = 1;
        for (int n = 0; n < NPF; n++) m_upd[n] = 0;
        if (l0 && int'(cfg_func) < NPF) begin
            if (cfg_add == 4'h0) begin
                m_mps[cfg_func]  = cfg_ctl[2:0];
                m_mrrs[cfg_func] = cfg_ctl[5:3];
                m_ext[cfg_func]  = cfg_ctl[6];
                m_upd[cfg_func]  = 1;
            end else if (cfg_add == 4'h6) begin
                m_msix[cfg_func] = cfg_ctl[5];
                m_mask[cfg_func] = cfg_ctl[6];
                m_upd[cfg_func]  = 1;
            end
        end
`ifdef PCIE_CFG_LINKDOWN_CLR_EN
        if (drop) begin
            model_clear_cfg();
            for (int n = 0; n < NPF; n++) m_upd[n] = 0;
        end
`endif
        m_ltssm = ltssm;
    endtask

    // ---------------- per-cycle compare ----------------
    logic [3*NPF-1:0] e_mps, e_mrrs;
    logic [NPF-1:0]   e_ext, e_msix, e_mask, e_upd;

    always @(negedge clk) begin
        if (m_valid) begin
            for (int n = 0; n < NPF; n++) begin
                e_mps[3*n +: 3]  = m_mps[n];
                e_mrrs[3*n +: 3] = m_mrrs[n];
                e_ext[n]  = m_ext[n];
                e_msix[n] = m_msix[n];
                e_mask[n] = m_mask[n];
                e_upd[n]  = m_upd[n];
            end
            check("linkup",   32'(pcie_linkup), 32'(m_linkup));
            check("bd_done",  32'(bd_done),     32'(m_bd));
            check("down_cnt", 32'(down_cnt),    32'(m_dcnt));
            check("mps",      32'(mps),         32'(e_mps));
            check("mrrs",     32'(mrrs),        32'(e_mrrs));
            check("ext_tag",  32'(ext_tag),     32'(e_ext));
            check("msix_en",  32'(msix_en),     32'(e_msix));
            check("msix_msk", 32'(msix_mask),   32'(e_mask));
            check("cfg_upd",  32'(cfg_update),  32'(e_upd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic [5:0] lt, input logic lk,
                        input logic [1:0] fn, input logic [3:0] ad, input logic [31:0] ct);
        @(negedge clk);
        rst_n = r; ltssm = lt; hip_linkup = lk; cfg_func = fn; cfg_add = ad; cfg_ctl = ct;
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input logic lk);
        step(1'b1, L0, lk, 2'd0, 4'hF, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b0, 6'h0, 1'b0, 2'd0, 4'hF, 32'h0);
    endtask

    initial begin
        logic [3:0] ad;

        repeat (3) do_reset();
        #2;
        check("rst_linkup",  32'(pcie_linkup), 32'd0);
        check("rst_cnt",     32'(down_cnt),    32'd0);
        check("rst_bd_done", 32'(bd_done),     32'd0);
        check("rst_mps",     32'(mps),         32'd0);

        // Link-up timing from the cycle L0 is first applied.
        for (int i = 1; i <= DBC + 4; i++) begin
            idle(1'b1);
            #2;
            if (i == 1)       check("bd_done_c1", 32'(bd_done), 32'd0);
            if (i == 2)       check("bd_done_c2", 32'(bd_done), 32'd1);
            if (i == DBC + 1) check("linkup_c17", 32'(pcie_linkup), 32'd0);
            if (i == DBC + 2) check("linkup_c18", 32'(pcie_linkup), 32'd1);
        end

        // Config capture for PF2, then an out-of-range function.
        step(1'b1, L0, 1'b1, 2'd2, 4'h0, 32'h0000_006A);
        #2;
        check("mps_pf2",   32'(mps[8:6]),   32'd2);
        check("mrrs_pf2",  32'(mrrs[8:6]),  32'd5);
        check("ext_pf2",   32'(ext_tag[2]), 32'd1);
        check("upd_pulse", 32'(cfg_update), 32'h4);
        idle(1'b1);
        #2;
        check("upd_clear", 32'(cfg_update), 32'h0);
        step(1'b1, L0, 1'b1, 2'd3, 4'h0, 32'h0000_007F);
        #2;
        check("func3_mps", 32'(mps),        32'h080);
        check("func3_upd", 32'(cfg_update), 32'h0);

        // MSI-X enable for PF0, then a link drop.
        step(1'b1, L0, 1'b1, 2'd0, 4'h6, 32'h0000_0060);
        #2;
        check("msix0_set", 32'(msix_en[0]), 32'd1);
        idle(1'b0);
        #2;
        check("drop_linkup", 32'(pcie_linkup), 32'd0);
        check("drop_cnt1",   32'(down_cnt),    32'd1);
`ifdef PCIE_CFG_LINKDOWN_CLR_EN
        check("msix0_drop", 32'(msix_en[0]), 32'd0);
`else
        check("msix0_drop", 32'(msix_en[0]), 32'd1);
`endif

        // Two more re-link / drop rounds.
        repeat (2) begin
            repeat (DBC + 1) idle(1'b1);
            idle(1'b0);
        end
        #2;
        check("drop_cnt3", 32'(down_cnt), 32'd3);

        // qual drops at debounce count 10, then the full debounce restarts.
        do_reset();
        repeat (11) idle(1'b1);
        idle(1'b0);
        #2;
        check("abort_linkup", 32'(pcie_linkup), 32'd0);
        for (int i = 1; i <= DBC + 1; i++) begin
            idle(1'b1);
            #2;
            if (i == DBC)     check("restart_c16", 32'(pcie_linkup), 32'd0);
            if (i == DBC + 1) check("restart_c17", 32'(pcie_linkup), 32'd1);
        end

        // Reset while UP with a nonzero drop count and config loaded.
        idle(1'b0);
        repeat (DBC + 1) idle(1'b1);
        step(1'b1, L0, 1'b1, 2'd1, 4'h0, 32'h0000_003F);
        #2;
        check("pre_rst_up", 32'(pcie_linkup), 32'd1);
        do_reset();
        #2;
        check("rst_up_linkup", 32'(pcie_linkup), 32'd0);
        check("rst_up_cnt",    32'(down_cnt),    32'd0);
        check("rst_up_mps",    32'(mps),         32'd0);
        check("rst_up_mrrs",   32'(mrrs),        32'd0);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       ad = 4'h0;
                1:       ad = 4'h6;
                default: ad = 4'($urandom_range(0, 15));
            endcase
            step(($urandom_range(0, 399) != 0),
                 ($urandom_range(0, 29) == 0) ? 6'($urandom_range(0, 63)) : L0,
                 ($urandom_range(0, 39) != 0),
                 2'($urandom_range(0, 3)),
                 ad,
                 $urandom);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
